// File: rtl/walu_pkg.sv
// Shared types and defaults for the WALU stream driver and its response buffer.
package walu_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int RESP_DEPTH = 4;

  typedef logic [DATA_WIDTH-1:0] data_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLL = 3'd5,
    OP_SRL = 3'd6,
    OP_SRA = 3'd7
  } op_t;
endpackage

// File: rtl/walu_resp_fifo.sv
// Response buffer: power-of-two depth FIFO with occupancy count and show-ahead head output.
module walu_resp_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic [CW-1:0]    count,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is cleared too so the head reads zero out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_wr) - CW'(do_rd);
    end
  end

  a_no_write_when_full: assert property (@(posedge clk) disable iff (rst) !(wr_en && full))
    else $error("walu_resp_fifo: write attempted while full");
endmodule

// File: rtl/walu_stream_driver.sv
// Streams tagged requests through an external combinational ALU and buffers the tagged results.
module walu_stream_driver #(
  parameter int DATA_WIDTH = walu_pkg::DATA_WIDTH,
  parameter int RESP_DEPTH = walu_pkg::RESP_DEPTH,
  parameter int TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  input  walu_pkg::op_t         req_op,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output walu_pkg::op_t         alu_op,
  input  logic [DATA_WIDTH-1:0] alu_res,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_res,
  output logic [TAG_WIDTH-1:0]  resp_tag
);
  import walu_pkg::*;

  localparam int CW = $clog2(RESP_DEPTH) + 1;
  localparam int FW = TAG_WIDTH + DATA_WIDTH;

  logic [DATA_WIDTH-1:0] a_p0;
  logic [DATA_WIDTH-1:0] b_p0;
  op_t                   op_p0;
  logic [TAG_WIDTH-1:0]  tag_p0;
  logic                  vld_p0;
  logic [TAG_WIDTH-1:0]  tag_cnt;
  logic [CW-1:0]         fifo_count;
  logic [CW:0]           occupancy;
  logic                  fifo_empty;
  logic [FW-1:0]         head;
  logic                  accept;

  // Issue stage counts toward occupancy so its pending write always has a free slot.
  assign occupancy = {1'b0, fifo_count} + {{CW{1'b0}}, vld_p0};
  assign req_ready = (occupancy < (CW+1)'(RESP_DEPTH));
  assign accept    = req_valid && req_ready;

  // Stage p0: issue registers feeding the ALU; operands hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p0    <= '0;
      b_p0    <= '0;
      op_p0   <= OP_ADD;
      tag_p0  <= '0;
      vld_p0  <= 1'b0;
      tag_cnt <= '0;
    end else begin
      vld_p0 <= accept;
      if (accept) begin
        a_p0    <= req_a;
        b_p0    <= req_b;
        op_p0   <= req_op;
        tag_p0  <= tag_cnt;
        tag_cnt <= tag_cnt + 1'b1;
      end
    end
  end

  assign alu_a  = a_p0;
  assign alu_b  = b_p0;
  assign alu_op = op_p0;

  // Stage p1: ALU result captured with its tag into the response FIFO.
  walu_resp_fifo #(
    .WIDTH (FW),
    .DEPTH (RESP_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (vld_p0),
    .wr_data ({tag_p0, alu_res}),
    .rd_en   (resp_ready),
    .rd_data (head),
    .count   (fifo_count),
    .empty   (fifo_empty)
  );

  assign resp_valid           = !fifo_empty;
  assign {resp_tag, resp_res} = head;
endmodule

// File: tb/tb_walu_stream_driver.sv
// Scoreboard bench for walu_stream_driver with a behavioural ALU closing the loop.
module tb_walu_stream_driver;
  import walu_pkg::*;

  typedef struct {
    data_t      res;
    logic [3:0] tag;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  data_t      req_a;
  data_t      req_b;
  op_t        req_op;
  data_t      alu_a;
  data_t      alu_b;
  op_t        alu_op;
  data_t      alu_res;
  logic       resp_valid;
  logic       resp_ready;
  data_t      resp_res;
  logic [3:0] resp_tag;

  exp_t       exp_q[$];
  logic [3:0] exp_tag;
  int         n_vec;
  int         n_miss;

  walu_stream_driver dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_res    (alu_res),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_res   (resp_res),
    .resp_tag   (resp_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic data_t alu_f(input data_t a, input data_t b, input op_t op);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      default: return data_t'($signed(a) >>> b[4:0]);
    endcase
  endfunction

  assign alu_res = alu_f(alu_a, alu_b, alu_op);

  // One bus cycle: at the falling edge sample outputs, drive inputs, and report the transfers the next rising edge will make.
  task automatic cyc(input logic rv, input data_t a, input data_t b, input op_t op, input logic rr,
                     output logic acc, output logic pop, output data_t res, output logic [3:0] tg);
    @(negedge clk);
    req_valid  = rv;
    req_a      = a;
    req_b      = b;
    req_op     = op;
    resp_ready = rr;
    acc = rv && req_ready;
    pop = resp_valid && rr;
    res = resp_res;
    tg  = resp_tag;
  endtask

  task automatic push_exp(input data_t a, input data_t b, input op_t op);
    exp_t e;
    e.res = alu_f(a, b, op);
    e.tag = exp_tag;
    exp_q.push_back(e);
    exp_tag = exp_tag + 4'd1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    exp_tag = 4'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    req_a = '0;
    req_b = '0;
    req_op = OP_ADD;
    resp_ready = 1'b0;
    exp_tag = 4'd0;
    #3;
    n_vec++; if (resp_valid !== 1'b0) begin n_miss++; $display("FAIL rst_resp_valid: got %b want 0", resp_valid); end
    n_vec++; if (resp_res !== '0) begin n_miss++; $display("FAIL rst_resp_res: got %h want 0", resp_res); end
    n_vec++; if (resp_tag !== 4'd0) begin n_miss++; $display("FAIL rst_resp_tag: got %h want 0", resp_tag); end
    n_vec++; if (alu_a !== '0 || alu_b !== '0) begin n_miss++; $display("FAIL rst_alu_ab: got %h/%h want 0/0", alu_a, alu_b); end
    n_vec++; if (alu_op !== OP_ADD) begin n_miss++; $display("FAIL rst_alu_op: got %0d want %0d", alu_op, OP_ADD); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_vec++; if (req_ready !== 1'b1) begin n_miss++; $display("FAIL rst_req_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_single();
    logic acc, pop;
    data_t r;
    logic [3:0] t;
    do_reset();
    cyc(1'b1, 32'd5, 32'd3, OP_ADD, 1'b1, acc, pop, r, t);
    n_vec++; if (acc !== 1'b1) begin n_miss++; $display("FAIL single_accept: got %b want 1", acc); end
    cyc(1'b0, '0, '0, OP_ADD, 1'b1, acc, pop, r, t);
    n_vec++; if (pop !== 1'b0) begin n_miss++; $display("FAIL single_early_resp: got %b want 0", pop); end
    n_vec++; if (alu_a !== 32'd5 || alu_b !== 32'd3) begin n_miss++; $display("FAIL single_issue: got %h/%h want 5/3", alu_a, alu_b); end
    cyc(1'b0, '0, '0, OP_ADD, 1'b1, acc, pop, r, t);
    n_vec++; if (pop !== 1'b1) begin n_miss++; $display("FAIL single_latency: got %b want 1", pop); end
    n_vec++; if (r !== 32'd8 || t !== 4'd0) begin n_miss++; $display("FAIL single_result: got %h tag %0d want 8 tag 0", r, t); end
    cyc(1'b0, 32'd77, 32'd66, OP_SUB, 1'b1, acc, pop, r, t);
    n_vec++; if (resp_valid !== 1'b0) begin n_miss++; $display("FAIL single_drained: got %b want 0", resp_valid); end
    n_vec++; if (alu_a !== 32'd5 || alu_op !== OP_ADD) begin n_miss++; $display("FAIL single_alu_hold: got %h op %0d want 5 op 0", alu_a, alu_op); end
  endtask

  task automatic test_backpressure();
    logic acc, pop;
    data_t r;
    logic [3:0] t;
    exp_t e;
    int nacc;
    do_reset();
    nacc = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, data_t'(nacc + 10), data_t'(nacc), OP_ADD, 1'b0, acc, pop, r, t);
      n_vec++;
      if (acc !== (nacc < 4)) begin n_miss++; $display("FAIL bp_ready_cycle%0d: got %b want %b", i, acc, (nacc < 4)); end
      if (acc) begin push_exp(data_t'(nacc + 10), data_t'(nacc), OP_ADD); nacc++; end
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
      cyc(1'b0, '0, '0, OP_ADD, 1'b1, acc, pop, r, t);
      if (pop) begin
        e = exp_q.pop_front();
        n_vec++;
        if (r !== e.res || t !== e.tag) begin n_miss++; $display("FAIL bp_drain: got %h tag %0d want %h tag %0d", r, t, e.res, e.tag); end
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_miss++; $display("FAIL bp_drain_timeout: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_stream();
    logic acc, pop, rv, started;
    data_t r, a, b;
    logic [3:0] t;
    op_t op;
    exp_t e;
    int sent, got;
    do_reset();
    sent = 0; got = 0; started = 1'b0;
    for (int c = 0; c < 60 && got < 17; c++) begin
      rv = (sent < 17);
      a = $urandom;
      b = $urandom;
      op = op_t'(sent[2:0]);
      cyc(rv, a, b, op, 1'b1, acc, pop, r, t);
      if (rv) begin
        n_vec++; if (acc !== 1'b1) begin n_miss++; $display("FAIL stream_accept%0d: got %b want 1", sent, acc); end
      end
      if (acc) begin push_exp(a, b, op); sent++; end
      if (started) begin
        n_vec++; if (pop !== 1'b1) begin n_miss++; $display("FAIL stream_bubble: got %b want 1", pop); end
      end
      if (pop) begin
        started = 1'b1;
        got++;
        n_vec++;
        if (exp_q.size() == 0) begin n_miss++; $display("FAIL stream_extra: got tag %0d want none", t); end
        else begin
          e = exp_q.pop_front();
          if (r !== e.res || t !== e.tag) begin n_miss++; $display("FAIL stream_resp: got %h tag %0d want %h tag %0d", r, t, e.res, e.tag); end
        end
      end
    end
    n_vec++; if (got != 17) begin n_miss++; $display("FAIL stream_timeout: got %0d want 17", got); end
  endtask

  task automatic test_toggle();
    logic acc, pop, rv, rr, held;
    data_t r, held_res;
    logic [3:0] t, held_tag;
    exp_t e;
    int sent, got;
    do_reset();
    sent = 0; got = 0; held = 1'b0; held_res = '0; held_tag = '0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      rr = c[0];
      rv = (sent < 8);
      cyc(rv, 32'hFFFF_FFFF, 32'd1, OP_ADD, rr, acc, pop, r, t);
      if (held) begin
        n_vec++;
        if (resp_res !== held_res || resp_tag !== held_tag) begin n_miss++; $display("FAIL toggle_stable: got %h tag %0d want %h tag %0d", resp_res, resp_tag, held_res, held_tag); end
      end
      held = resp_valid && !rr;
      held_res = resp_res;
      held_tag = resp_tag;
      if (acc) begin push_exp(32'hFFFF_FFFF, 32'd1, OP_ADD); sent++; end
      if (pop) begin
        got++;
        n_vec++;
        if (exp_q.size() == 0) begin n_miss++; $display("FAIL toggle_extra: got tag %0d want none", t); end
        else begin
          e = exp_q.pop_front();
          if (r !== 32'h0 || t !== e.tag) begin n_miss++; $display("FAIL toggle_resp: got %h tag %0d want 0 tag %0d", r, t, e.tag); end
        end
      end
    end
    n_vec++; if (got != 8) begin n_miss++; $display("FAIL toggle_timeout: got %0d want 8", got); end
  endtask

  task automatic test_async_reset();
    logic acc, pop;
    data_t r;
    logic [3:0] t;
    exp_t e;
    logic seen;
    do_reset();
    for (int i = 0; i < 3; i++) cyc(1'b1, data_t'(i + 1), 32'd1, OP_ADD, 1'b0, acc, pop, r, t);
    cyc(1'b0, '0, '0, OP_ADD, 1'b0, acc, pop, r, t);
    cyc(1'b0, '0, '0, OP_ADD, 1'b0, acc, pop, r, t);
    n_vec++; if (dut.u_fifo.count !== 3'd3) begin n_miss++; $display("FAIL arst_prefill: got %0d want 3", dut.u_fifo.count); end
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_vec++; if (resp_valid !== 1'b0) begin n_miss++; $display("FAIL arst_immediate: got %b want 0", resp_valid); end
    n_vec++; if (resp_res !== '0 || resp_tag !== 4'd0) begin n_miss++; $display("FAIL arst_outputs: got %h tag %0d want 0 tag 0", resp_res, resp_tag); end
    exp_q.delete();
    exp_tag = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, '0, OP_ADD, 1'b1, acc, pop, r, t);
      n_vec++; if (resp_valid !== 1'b0) begin n_miss++; $display("FAIL arst_ghost: got %b want 0", resp_valid); end
    end
    cyc(1'b1, 32'd7, 32'd9, OP_ADD, 1'b1, acc, pop, r, t);
    if (acc) push_exp(32'd7, 32'd9, OP_ADD);
    seen = 1'b0;
    for (int i = 0; i < 6 && !seen; i++) begin
      cyc(1'b0, '0, '0, OP_ADD, 1'b1, acc, pop, r, t);
      if (pop) begin
        seen = 1'b1;
        n_vec++;
        if (r !== 32'd16 || t !== 4'd0) begin n_miss++; $display("FAIL arst_new_req: got %h tag %0d want 10 tag 0", r, t); end
        if (exp_q.size() != 0) e = exp_q.pop_front();
      end
    end
    n_vec++; if (!seen) begin n_miss++; $display("FAIL arst_timeout: got none want one response"); end
  endtask

  task automatic test_push_pop();
    logic acc, pop;
    data_t r;
    logic [3:0] t;
    exp_t e;
    // Simultaneous push/pop with one entry buffered.
    do_reset();
    cyc(1'b1, 32'd100, 32'd1, OP_ADD, 1'b0, acc, pop, r, t);
    if (acc) push_exp(32'd100, 32'd1, OP_ADD);
    cyc(1'b1, 32'd200, 32'd2, OP_ADD, 1'b0, acc, pop, r, t);
    if (acc) push_exp(32'd200, 32'd2, OP_ADD);
    cyc(1'b0, '0, '0, OP_ADD, 1'b1, acc, pop, r, t);
    n_vec++; if (dut.u_fifo.count !== 3'd1) begin n_miss++; $display("FAIL pp1_before: got %0d want 1", dut.u_fifo.count); end
    n_vec++; if (pop !== 1'b1 || r !== 32'd101) begin n_miss++; $display("FAIL pp1_head: got %h want 65", r); end
    if (pop && exp_q.size() != 0) e = exp_q.pop_front();
    cyc(1'b0, '0, '0, OP_ADD, 1'b0, acc, pop, r, t);
    n_vec++; if (dut.u_fifo.count !== 3'd1) begin n_miss++; $display("FAIL pp1_after: got %0d want 1", dut.u_fifo.count); end
    n_vec++; if (resp_res !== 32'd202 || resp_tag !== 4'd1) begin n_miss++; $display("FAIL pp1_advance: got %h tag %0d want ca tag 1", resp_res, resp_tag); end
    // Simultaneous push/pop with RESP_DEPTH-1 entries buffered.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, data_t'(300 + i), data_t'(i), OP_ADD, 1'b0, acc, pop, r, t);
      n_vec++; if (acc !== 1'b1) begin n_miss++; $display("FAIL pp3_fill%0d: got %b want 1", i, acc); end
      if (acc) push_exp(data_t'(300 + i), data_t'(i), OP_ADD);
    end
    cyc(1'b1, 32'd999, 32'd0, OP_ADD, 1'b1, acc, pop, r, t);
    n_vec++; if (dut.u_fifo.count !== 3'd3 || acc !== 1'b0) begin n_miss++; $display("FAIL pp3_before: got count %0d acc %b want 3 acc 0", dut.u_fifo.count, acc); end
    if (pop) begin
      e = exp_q.pop_front();
      n_vec++; if (r !== e.res || t !== e.tag) begin n_miss++; $display("FAIL pp3_head: got %h tag %0d want %h tag %0d", r, t, e.res, e.tag); end
    end
    cyc(1'b0, '0, '0, OP_ADD, 1'b0, acc, pop, r, t);
    n_vec++; if (dut.u_fifo.count !== 3'd3) begin n_miss++; $display("FAIL pp3_after: got %0d want 3", dut.u_fifo.count); end
    n_vec++; if (resp_res !== 32'd302 || resp_tag !== 4'd1) begin n_miss++; $display("FAIL pp3_advance: got %h tag %0d want 12e tag 1", resp_res, resp_tag); end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      cyc(1'b0, '0, '0, OP_ADD, 1'b1, acc, pop, r, t);
      if (pop) begin
        e = exp_q.pop_front();
        n_vec++; if (r !== e.res || t !== e.tag) begin n_miss++; $display("FAIL pp3_drain: got %h tag %0d want %h tag %0d", r, t, e.res, e.tag); end
      end
    end
    n_vec++; if (exp_q.size() != 0) begin n_miss++; $display("FAIL pp3_timeout: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    n_vec = 0;
    n_miss = 0;
    test_reset();
    test_single();
    test_backpressure();
    test_stream();
    test_toggle();
    test_async_reset();
    test_push_pop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
